// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: the x0 register
// number, the load-tracker state encoding and the forwarding-select width.
package hazard_fwd_ctrl_pkg;

    localparam int unsigned REG_X0 = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ld_state_e;

    // Select code NSTG means "no matching stage", hence one spare code.
    function automatic int unsigned fwd_sel_w(input int unsigned nstg);
        return $clog2(nstg + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_port_sel.sv
// One source operand's priority match across the forwarding stages: picks the
// youngest matching writer and forwards it if ready, otherwise flags a hazard.
module fwd_port_sel
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5,
    parameter int unsigned NSTG = 3
) (
    input  logic [RAW-1:0]       i_rs,
    input  logic                 i_used,
    input  logic [NSTG-1:0]      i_stg_valid,
    input  logic [NSTG-1:0]      i_stg_we,
    input  logic [NSTG*RAW-1:0]  i_stg_rd,
    input  logic [NSTG-1:0]      i_stg_rdy,
    input  logic [NSTG*XLEN-1:0] i_stg_dat,
    output logic                 o_en,
    output logic [XLEN-1:0]      o_dat,
    output logic                 o_hazard
);

    localparam int unsigned SELW = fwd_sel_w(NSTG);

    logic [NSTG-1:0] w_match;
    logic [SELW-1:0] w_sel;

    // Per-stage match of this operand against each in-flight destination
    always_comb begin
        w_match = '0;
        for (int s = 0; s < int'(NSTG); s++) begin
            w_match[s] = i_used && (i_rs != RAW'(REG_X0)) && i_stg_valid[s] && i_stg_we[s]
                         && (i_stg_rd[s*RAW +: RAW] == i_rs);
        end
    end

    // Youngest match wins: scan oldest to youngest so lower indices overwrite
    always_comb begin
        w_sel = SELW'(NSTG);
        for (int s = int'(NSTG) - 1; s >= 0; s--) begin
            if (w_match[s]) begin
                w_sel = SELW'(s);
            end else begin
                w_sel = w_sel;
            end
        end
    end

    // A not-ready winner blocks forwarding even if an older stage is ready
    always_comb begin
        o_en     = 1'b0;
        o_dat    = '0;
        o_hazard = 1'b0;
        for (int s = 0; s < int'(NSTG); s++) begin
            if (w_sel == SELW'(s)) begin
                if (i_stg_rdy[s]) begin
                    o_en  = 1'b1;
                    o_dat = i_stg_dat[s*XLEN +: XLEN];
                end else begin
                    o_hazard = 1'b1;
                end
            end else begin
                o_en = o_en;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and hazard controller beside decode: per-operand forwarding,
// single outstanding load tracking, stall generation and stall statistics.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NSTG = 3,
    parameter int unsigned CNTW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NRD*RAW-1:0]   id_rs_i,
    input  logic [NRD-1:0]       id_rs_used_i,
    input  logic [NSTG-1:0]      stg_valid_i,
    input  logic [NSTG-1:0]      stg_we_i,
    input  logic [NSTG*RAW-1:0]  stg_rd_i,
    input  logic [NSTG-1:0]      stg_rdy_i,
    input  logic [NSTG*XLEN-1:0] stg_dat_i,
    input  logic                 mem_req_i,
    input  logic [RAW-1:0]       mem_rd_i,
    input  logic                 mem_ack_i,
    output logic [NRD-1:0]       fwd_en_o,
    output logic [NRD*XLEN-1:0]  fwd_dat_o,
    output logic                 stall_o,
    output logic [CNTW-1:0]      stall_cnt_o,
    output logic                 err_o
);

    ld_state_e       r_state;
    logic [RAW-1:0]  r_pend_rd;
    logic [CNTW-1:0] r_stall_cnt;
    logic            r_err;

    logic [NRD-1:0]      w_en;
    logic [NRD*XLEN-1:0] w_dat;
    logic [NRD-1:0]      w_haz;
    logic [NRD-1:0]      w_haz_ld;

    for (genvar p = 0; p < int'(NRD); p++) begin : g_port
        fwd_port_sel #(
            .XLEN (XLEN),
            .RAW  (RAW),
            .NSTG (NSTG)
        ) u_sel (
            .i_rs        (id_rs_i[p*RAW +: RAW]),
            .i_used      (id_rs_used_i[p]),
            .i_stg_valid (stg_valid_i),
            .i_stg_we    (stg_we_i),
            .i_stg_rd    (stg_rd_i),
            .i_stg_rdy   (stg_rdy_i),
            .i_stg_dat   (stg_dat_i),
            .o_en        (w_en[p]),
            .o_dat       (w_dat[p*XLEN +: XLEN]),
            .o_hazard    (w_haz[p])
        );
    end

    // Load-use hazard: operand reads the register the pending load will write
    always_comb begin
        w_haz_ld = '0;
        for (int p = 0; p < int'(NRD); p++) begin
            w_haz_ld[p] = (r_state == ST_WAIT) && !mem_ack_i && id_rs_used_i[p]
                          && (id_rs_i[p*RAW +: RAW] != RAW'(REG_X0))
                          && (id_rs_i[p*RAW +: RAW] == r_pend_rd);
        end
    end

    assign fwd_en_o    = rst_i ? '0 : w_en;
    assign fwd_dat_o   = rst_i ? '0 : w_dat;
    assign stall_o     = !rst_i && ((|w_haz) || (|w_haz_ld));
    assign stall_cnt_o = r_stall_cnt;
    assign err_o       = r_err;

    // Load tracker FSM, pending destination, saturating stall counter, error flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_pend_rd   <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (stall_o && (r_stall_cnt != {CNTW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        r_state   <= ST_WAIT;
                        r_pend_rd <= mem_rd_i;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i && mem_req_i) begin
                        r_pend_rd <= mem_rd_i;
                    end else if (mem_ack_i) begin
                        r_state <= ST_IDLE;
                    end else if (mem_req_i) begin
                        r_err <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: default instance plus a CNTW=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_hazard_fwd_ctrl;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int NRD  = 2;
    localparam int NSTG = 3;

    logic                 clk;
    logic                 rst;
    logic [NRD*RAW-1:0]   id_rs;
    logic [NRD-1:0]       id_used;
    logic [NSTG-1:0]      stg_valid;
    logic [NSTG-1:0]      stg_we;
    logic [NSTG*RAW-1:0]  stg_rd;
    logic [NSTG-1:0]      stg_rdy;
    logic [NSTG*XLEN-1:0] stg_dat;
    logic                 mem_req;
    logic [RAW-1:0]       mem_rd;
    logic                 mem_ack;

    logic [NRD-1:0]       fwd_en,  s_fwd_en;
    logic [NRD*XLEN-1:0]  fwd_dat, s_fwd_dat;
    logic                 stall,   s_stall;
    logic [15:0]          cnt;
    logic [1:0]           s_cnt;
    logic                 err,     s_err;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_fwd_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rs_used_i(id_used),
        .stg_valid_i(stg_valid), .stg_we_i(stg_we), .stg_rd_i(stg_rd),
        .stg_rdy_i(stg_rdy), .stg_dat_i(stg_dat), .mem_req_i(mem_req),
        .mem_rd_i(mem_rd), .mem_ack_i(mem_ack), .fwd_en_o(fwd_en),
        .fwd_dat_o(fwd_dat), .stall_o(stall), .stall_cnt_o(cnt), .err_o(err)
    );

    hazard_fwd_ctrl #(.CNTW(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rs_used_i(id_used),
        .stg_valid_i(stg_valid), .stg_we_i(stg_we), .stg_rd_i(stg_rd),
        .stg_rdy_i(stg_rdy), .stg_dat_i(stg_dat), .mem_req_i(mem_req),
        .mem_rd_i(mem_rd), .mem_ack_i(mem_ack), .fwd_en_o(s_fwd_en),
        .fwd_dat_o(s_fwd_dat), .stall_o(s_stall), .stall_cnt_o(s_cnt), .err_o(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_used = '0; stg_valid = '0; stg_we = '0; stg_rd = '0;
        stg_rdy = '0; stg_dat = '0; mem_req = 1'b0; mem_rd = '0; mem_ack = 1'b0;
    endtask

    task automatic set_stage(input int s, input logic [4:0] rd, input logic rdy, input logic [31:0] dat);
        stg_valid[s] = 1'b1;
        stg_we[s]    = 1'b1;
        stg_rd[s*RAW +: RAW]    = rd;
        stg_rdy[s]   = rdy;
        stg_dat[s*XLEN +: XLEN] = dat;
    endtask

    task automatic set_rs(input int p, input logic [4:0] rs, input logic used);
        id_rs[p*RAW +: RAW] = rs;
        id_used[p] = used;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        do_reset();

        // Reset state
        chk("rst_fwd_en", 32'(fwd_en), 32'h0);
        chk("rst_stall",  32'(stall),  32'h0);
        chk("rst_cnt",    32'(cnt),    32'h0);
        chk("rst_err",    32'(err),    32'h0);

        // 1: youngest ready match wins
        set_stage(0, 5'd5, 1'b1, 32'h11);
        set_stage(1, 5'd5, 1'b1, 32'h22);
        set_rs(0, 5'd5, 1'b1);
        #1;
        chk("t1_en",    32'(fwd_en), 32'h1);
        chk("t1_dat0",  fwd_dat[31:0],  32'h11);
        chk("t1_dat1",  fwd_dat[63:32], 32'h0);
        chk("t1_stall", 32'(stall), 32'h0);
        set_stage(0, 5'd6, 1'b1, 32'h11);
        #1;
        chk("t1_older", fwd_dat[31:0], 32'h22);

        // 2: younger not-ready match blocks older ready one
        clear_inputs();
        set_stage(0, 5'd7, 1'b0, 32'h44);
        set_stage(2, 5'd7, 1'b1, 32'h33);
        set_rs(1, 5'd7, 1'b1);
        #1;
        chk("t2_en",    32'(fwd_en), 32'h0);
        chk("t2_stall", 32'(stall),  32'h1);
        tick();
        chk("t2_cnt",   32'(cnt), 32'h1);
        set_rs(1, 5'd7, 1'b0);
        #1;
        chk("t2_unused", 32'(stall), 32'h0);

        // 3: load-use stall until ack
        do_reset();
        mem_req = 1'b1; mem_rd = 5'd9;
        tick();
        mem_req = 1'b0;
        set_rs(0, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall", 32'(stall), 32'h1);
            tick();
        end
        chk("t3_cnt", 32'(cnt), 32'h3);
        mem_ack = 1'b1;
        #1;
        chk("t3_ack_stall", 32'(stall), 32'h0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t3_idle_stall", 32'(stall), 32'h0);
        chk("t3_cnt_hold",   32'(cnt),   32'h3);

        // 4: x0 never forwarded nor stalled
        do_reset();
        set_stage(0, 5'd0, 1'b1, 32'h55);
        set_stage(1, 5'd0, 1'b1, 32'h66);
        set_stage(2, 5'd0, 1'b1, 32'h77);
        set_rs(0, 5'd0, 1'b1);
        #1;
        chk("t4_en",    32'(fwd_en), 32'h0);
        chk("t4_stall", 32'(stall),  32'h0);
        clear_inputs();
        mem_req = 1'b1; mem_rd = 5'd0;
        tick();
        mem_req = 1'b0;
        set_rs(0, 5'd0, 1'b1);
        #1;
        chk("t4_ld_x0", 32'(stall), 32'h0);

        // 5: protocol error keeps pend_rd; back-to-back replaces it
        do_reset();
        mem_req = 1'b1; mem_rd = 5'd3;
        tick();
        mem_rd = 5'd4;
        tick();
        mem_req = 1'b0;
        chk("t5_err", 32'(err), 32'h1);
        set_rs(0, 5'd3, 1'b1);
        #1;
        chk("t5_pend3", 32'(stall), 32'h1);
        set_rs(0, 5'd4, 1'b1);
        #1;
        chk("t5_not4", 32'(stall), 32'h0);
        mem_req = 1'b1; mem_ack = 1'b1; mem_rd = 5'd4;
        tick();
        mem_req = 1'b0; mem_ack = 1'b0;
        #1;
        chk("t5_b2b_pend4", 32'(stall), 32'h1);
        set_rs(0, 5'd3, 1'b1);
        #1;
        chk("t5_b2b_not3", 32'(stall), 32'h0);
        tick();
        chk("t5_err_sticky", 32'(err), 32'h1);

        // 6: saturation on the 2-bit counter, then reset mid-WAIT
        do_reset();
        set_stage(0, 5'd6, 1'b0, 32'h0);
        set_rs(0, 5'd6, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_sat",    32'(s_cnt), 32'h3);
        chk("t6_wide",   32'(cnt),   32'h6);
        clear_inputs();
        mem_req = 1'b1; mem_rd = 5'd8;
        tick();
        mem_rd = 5'd1;
        tick();
        mem_req = 1'b0;
        set_rs(0, 5'd8, 1'b1);
        set_stage(1, 5'd2, 1'b1, 32'hAB);
        set_rs(1, 5'd2, 1'b1);
        #1;
        chk("t6_wait_stall", 32'(stall),    32'h1);
        chk("t6_err_pre",    32'(s_err),    32'h1);
        chk("t6_fwd_pre",    32'(fwd_en),   32'h2);
        rst = 1'b1;
        #1;
        chk("t6_rst_stall", 32'(stall),          32'h0);
        chk("t6_rst_en",    32'(fwd_en),         32'h0);
        chk("t6_rst_dat",   fwd_dat[63:32],      32'h0);
        chk("t6_rst_cnt",   32'(s_cnt),          32'h0);
        chk("t6_rst_err",   32'(err),            32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_idle_stall", 32'(stall),         32'h0);
        chk("t6_post_en",    32'(fwd_en),        32'h2);
        chk("t6_post_dat",   fwd_dat[63:32],     32'hAB);
        tick();
        chk("t6_post_err",   32'(err),           32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
